head_table_lookup: RTL and testbench
====================================

Name: head_table_lookup

Overview:
- Pipeline stage directly upstream of the data table.
- Takes a hashed request (bucket plus key/value/command) and reads the head pointer for that bucket from the head table RAM. Forwards the request together with head_ptr and head_ptr_val to the data-table search stage.
- Owns the head table RAM. Accepts head-pointer updates written back by the data table.
- Provides a sweep that clears the whole head table.

Parameters:
- BUCKET_WIDTH, 8, head table address width (2^BUCKET_WIDTH buckets).
- HEAD_PTR_WIDTH, 8, width of a data-table pointer.
- KEY_WIDTH, 32, key width.
- VALUE_WIDTH, 16, value width.
- OUT_BUF_DEPTH, 4, output buffer entries; must be >= 3.

Ports:
- clk_i  in  1  clock; single clock domain.
- rst_i  in  1  reset, asynchronous, active-high.
- in_valid_i  in  1  request valid.
- in_ready_o  out  1  request accepted when in_valid_i && in_ready_o.
- in_cmd_i  in  2  ht_cmd_t (SEARCH/INSERT/DELETE).
- in_bucket_i  in  BUCKET_WIDTH  hashed bucket index.
- in_key_i  in  KEY_WIDTH  key.
- in_value_i  in  VALUE_WIDTH  value.
- out_valid_o  out  1  result valid.
- out_ready_i  in  1  downstream ready.
- out_cmd_o, out_bucket_o, out_key_o, out_value_o  out  as inputs  request passed through.
- out_head_ptr_o  out  HEAD_PTR_WIDTH  head pointer of the bucket.
- out_head_ptr_val_o  out  1  bucket non-empty.
- hw_en_i  in  1  head write strobe from the data table.
- hw_bucket_i  in  BUCKET_WIDTH  bucket to update.
- hw_ptr_i  in  HEAD_PTR_WIDTH  new head pointer.
- hw_ptr_val_i  in  1  new valid flag (0 = bucket now empty).
- clear_run_i  in  1  pulse: start the clear sweep.
- clear_done_o  out  1  one-cycle pulse when the sweep finishes.

Behaviour:
- Reset values:
  - All outputs 0.
  - Output buffer empty; in-flight count 0; clear FSM in IDLE.
  - RAM contents are not reset; software issues clear_run_i after reset.
- RAM:
  - Simple dual-port, write port shared between hw_* and the clear sweep.
  - Read latency 1, registered address, old-data on read-during-write.
- Pipeline:
  - Accept at cycle N: RAM read issued at N. Data captured at N+1 into the output buffer.
  - out_valid_o is asserted at N+2 at the earliest (latency 2).
- Throughput and flow control:
  - 1 request/cycle while out_ready_i is held high.
  - in_ready_o = (clear FSM IDLE) && (buf_cnt + inflight_cnt < OUT_BUF_DEPTH).
  - in_ready_o depends on registered state only, with no combinational path from out_ready_i.
- Write ordering:
  - The result reflects every hw write with hw_en_i high up to and including acceptance cycle N.
  - A same-bucket write in cycle N is bypassed into the result (new data wins).
  - Writes after N do not affect that result.
- Output buffer:
  - FIFO order; the head entry drives the out_* ports.
  - Pop on out_valid_o && out_ready_i.
  - Payload is held stable while out_valid_o=1 and out_ready_i=0.
- Clear FSM (IDLE, CLEAR):
  - IDLE→CLEAR on clear_run_i; address counter set to 0.
  - In CLEAR, write {ptr=0, ptr_val=0} at one address per cycle, incrementing the address.
  - When the write to the all-ones address occurs, clear_done_o=1 for that cycle and the FSM returns to IDLE.
  - clear_run_i while in CLEAR restarts from address 0.
  - hw_en_i during CLEAR is dropped.
  - Requests already in flight drain normally; new requests are blocked.
- Reset mid-operation: the FIFO, in-flight requests and the clear sweep are all discarded. Requests in flight are lost, not replayed.
- Boundary conditions:
  - Bucket 0 and bucket 2^BUCKET_WIDTH-1 behave like any other bucket.
  - Address counter wrap is impossible because CLEAR exits at the all-ones address.

Optional Feature:
- Macro: HEAD_TABLE_LOOKUP_STATS_EN.
- Defined:
  - Adds 32-bit counters stat_lookups_o (incremented on each output pop) and stat_empty_o (incremented on each pop with out_head_ptr_val_o=0).
  - Counters saturate at 0xFFFFFFFF, reset to 0, and are also zeroed by clear_run_i.
- Undefined: both ports exist and are driven constant 0; no counter logic.

Decomposition:
- Package hash_table holds:
  - the BUCKET_WIDTH, HEAD_PTR_WIDTH, KEY_WIDTH and VALUE_WIDTH constants;
  - ht_cmd_t;
  - head_ram_data_t {ptr, ptr_val}.
- Sub-module ht_lookup_out_buf: parameterised synchronous FIFO (depth OUT_BUF_DEPTH) with count output.
- The RAM is the team's standard simple dual-port block.

Test Plan:
- Reset, clear_run_i pulse → clear_done_o exactly 256 cycles later (BUCKET_WIDTH=8). A SEARCH on bucket 0x37 then returns head_ptr_val=0.
- hw write bucket 0x10 ptr 0x5A val 1, then SEARCH bucket 0x10 → out_head_ptr_o=0x5A, val=1, out_valid_o 2 cycles after acceptance.
- hw write bucket 0x22 ptr 0x11 in the same cycle a SEARCH on 0x22 is accepted → result ptr 0x11 (bypass). A write of 0x33 in the following cycle does not change that result.
- 100 back-to-back requests with out_ready_i=1 → 100 results on consecutive cycles, in order. With out_ready_i=0, in_ready_o deasserts after 4 outstanding requests and payload holds stable.
- clear_run_i while 3 requests are in flight → all 3 delivered, in_ready_o=0 until clear_done_o, and a concurrent hw write is dropped.
- Assert rst_i mid-stream with 2 outstanding results → out_valid_o=0 next cycle and no stale results afterwards.
- With STATS_EN, 10 lookups of which 4 hit empty buckets → stat_lookups_o=10, stat_empty_o=4.

Source files
------------

// File: rtl/head_table_lookup_pkg.sv
`timescale 1ns/1ps
// hash_table: shared widths and types for the hash table pipeline
//   BUCKET_WIDTH/HEAD_PTR_WIDTH/KEY_WIDTH/VALUE_WIDTH default widths,
//   ht_cmd_t request command, head_ram_data_t head table entry, clr_state_t sweep state
package hash_table;
    localparam int BUCKET_WIDTH = 8;
    localparam int HEAD_PTR_WIDTH = 8;
    localparam int KEY_WIDTH = 32;
    localparam int VALUE_WIDTH = 16;
    typedef enum logic [1:0] {
        HT_SEARCH = 2'd0,
        HT_INSERT = 2'd1,
        HT_DELETE = 2'd2
    } ht_cmd_t;
    typedef struct packed {
        logic [HEAD_PTR_WIDTH-1:0] ptr;
        logic ptr_val;
    } head_ram_data_t;
    typedef enum logic {
        CLR_IDLE,
        CLR_RUN
    } clr_state_t;
endpackage

// File: rtl/head_table_lookup_out_buf.sv
`timescale 1ns/1ps
// ht_lookup_out_buf: synchronous FIFO for completed lookups, head entry always presented
//   push_i/data_i enqueue, pop_i dequeues the head on data_o, count_o is the occupancy
module ht_lookup_out_buf #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4,
    localparam int AW = $clog2(DEPTH),
    localparam int CW = $clog2(DEPTH + 1)
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             push_i,
    input  logic [WIDTH-1:0] data_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] data_o,
    output logic [CW-1:0]    count_o
);
    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0] rd_ptr, wr_ptr;
    logic do_push, do_pop;

    assign do_pop = pop_i && count_o != '0;
    assign do_push = push_i && (count_o != CW'(DEPTH) || do_pop);
    assign data_o = mem[rd_ptr];

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
            rd_ptr <= '0;
            wr_ptr <= '0;
            count_o <= '0;
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= data_i;
                wr_ptr <= wr_ptr == AW'(DEPTH - 1) ? '0 : wr_ptr + 1'b1;
            end
            if (do_pop) rd_ptr <= rd_ptr == AW'(DEPTH - 1) ? '0 : rd_ptr + 1'b1;
            count_o <= count_o + CW'(do_push) - CW'(do_pop);
        end
    end
endmodule

// File: rtl/head_table_lookup.sv
`timescale 1ns/1ps
// head_table_lookup: reads the bucket head pointer for each hashed request and forwards it downstream
//   in_*  request handshake and payload (cmd/bucket/key/value)
//   out_* request passed through plus out_head_ptr_o/out_head_ptr_val_o, FIFO-ordered
//   hw_*  head pointer write-back from the data table
//   clear_run_i starts a sweep zeroing every bucket, clear_done_o pulses on the last write
//   stat_lookups_o/stat_empty_o counters exist only when HEAD_TABLE_LOOKUP_STATS_EN is defined
module head_table_lookup
    import hash_table::*;
#(
    parameter int BUCKET_WIDTH = hash_table::BUCKET_WIDTH,
    parameter int HEAD_PTR_WIDTH = hash_table::HEAD_PTR_WIDTH,
    parameter int KEY_WIDTH = hash_table::KEY_WIDTH,
    parameter int VALUE_WIDTH = hash_table::VALUE_WIDTH,
    parameter int OUT_BUF_DEPTH = 4
) (
    input  logic                      clk_i,
    input  logic                      rst_i,
    input  logic                      in_valid_i,
    output logic                      in_ready_o,
    input  ht_cmd_t                   in_cmd_i,
    input  logic [BUCKET_WIDTH-1:0]   in_bucket_i,
    input  logic [KEY_WIDTH-1:0]      in_key_i,
    input  logic [VALUE_WIDTH-1:0]    in_value_i,
    output logic                      out_valid_o,
    input  logic                      out_ready_i,
    output ht_cmd_t                   out_cmd_o,
    output logic [BUCKET_WIDTH-1:0]   out_bucket_o,
    output logic [KEY_WIDTH-1:0]      out_key_o,
    output logic [VALUE_WIDTH-1:0]    out_value_o,
    output logic [HEAD_PTR_WIDTH-1:0] out_head_ptr_o,
    output logic                      out_head_ptr_val_o,
    input  logic                      hw_en_i,
    input  logic [BUCKET_WIDTH-1:0]   hw_bucket_i,
    input  logic [HEAD_PTR_WIDTH-1:0] hw_ptr_i,
    input  logic                      hw_ptr_val_i,
    input  logic                      clear_run_i,
    output logic                      clear_done_o,
    output logic [31:0]               stat_lookups_o,
    output logic [31:0]               stat_empty_o
);
    localparam int PW = HEAD_PTR_WIDTH + 1;
    localparam int RW = 2 + BUCKET_WIDTH + KEY_WIDTH + VALUE_WIDTH;
    localparam int CW = $clog2(OUT_BUF_DEPTH + 1);

    logic [PW-1:0] ram [2**BUCKET_WIDTH];
    logic [PW-1:0] ram_q, byp_q, wr_data;
    logic [BUCKET_WIDTH-1:0] wr_addr, clr_addr;
    logic wr_en, accept, pop, live, s1_valid, byp_hit;
    logic [RW-1:0] s1_req;
    logic [RW+PW-1:0] buf_dout;
    logic [CW-1:0] buf_cnt;
    logic [1:0] out_cmd_raw;
    clr_state_t state;

    // live keeps in_ready_o low while reset is held; the one in-flight slot counts against buffer space
    assign in_ready_o = live && state == CLR_IDLE && int'(buf_cnt) + int'(s1_valid) < OUT_BUF_DEPTH;
    assign accept = in_valid_i && in_ready_o;
    assign out_valid_o = buf_cnt != '0;
    assign pop = out_valid_o && out_ready_i;
    assign wr_en = state == CLR_RUN || hw_en_i;
    assign wr_addr = state == CLR_RUN ? clr_addr : hw_bucket_i;
    assign wr_data = state == CLR_RUN ? '0 : {hw_ptr_i, hw_ptr_val_i};
    assign clear_done_o = state == CLR_RUN && &clr_addr && !clear_run_i;

    always_ff @(posedge clk_i) begin
        if (wr_en) ram[wr_addr] <= wr_data;
        ram_q <= ram[in_bucket_i];
    end

    // the RAM returns pre-write data, so a same-cycle write to the looked-up bucket is captured here
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            live <= 1'b0;
            s1_valid <= 1'b0;
            s1_req <= '0;
            byp_hit <= 1'b0;
            byp_q <= '0;
        end else begin
            live <= 1'b1;
            s1_valid <= accept;
            if (accept) begin
                s1_req <= {in_cmd_i, in_bucket_i, in_key_i, in_value_i};
                byp_hit <= hw_en_i && hw_bucket_i == in_bucket_i;
                byp_q <= {hw_ptr_i, hw_ptr_val_i};
            end
        end
    end

    ht_lookup_out_buf #(.WIDTH(RW + PW), .DEPTH(OUT_BUF_DEPTH)) u_out_buf (
        .clk_i(clk_i),
        .rst_i(rst_i),
        .push_i(s1_valid),
        .data_i({s1_req, byp_hit ? byp_q : ram_q}),
        .pop_i(pop),
        .data_o(buf_dout),
        .count_o(buf_cnt)
    );

    assign {out_cmd_raw, out_bucket_o, out_key_o, out_value_o, out_head_ptr_o, out_head_ptr_val_o} = buf_dout;
    assign out_cmd_o = ht_cmd_t'(out_cmd_raw);

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state <= CLR_IDLE;
            clr_addr <= '0;
        end else if (clear_run_i) begin
            state <= CLR_RUN;
            clr_addr <= '0;
        end else if (state == CLR_RUN) begin
            clr_addr <= clr_addr + 1'b1;
            if (&clr_addr) state <= CLR_IDLE;
        end
    end

`ifdef HEAD_TABLE_LOOKUP_STATS_EN
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            stat_lookups_o <= '0;
            stat_empty_o <= '0;
        end else if (clear_run_i) begin
            stat_lookups_o <= '0;
            stat_empty_o <= '0;
        end else if (pop) begin
            if (~&stat_lookups_o) stat_lookups_o <= stat_lookups_o + 1'b1;
            if (!out_head_ptr_val_o && ~&stat_empty_o) stat_empty_o <= stat_empty_o + 1'b1;
        end
    end
`else
    assign stat_lookups_o = '0;
    assign stat_empty_o = '0;
`endif
endmodule

// File: tb/tb_head_table_lookup.sv
`timescale 1ns/1ps
// tb_head_table_lookup: random and directed stimulus checked against a queue/array model of the lookup stage
module tb_head_table_lookup;
    import hash_table::*;

    localparam int DEPTH = 4;
`ifdef HEAD_TABLE_LOOKUP_STATS_EN
    localparam bit STATS = 1'b1;
`else
    localparam bit STATS = 1'b0;
`endif

    logic clk = 1'b0, rst = 1'b1;
    logic in_valid = 1'b0, out_ready = 1'b1, hw_en = 1'b0, hw_ptr_val = 1'b0, clear_run = 1'b0;
    ht_cmd_t in_cmd = HT_SEARCH;
    logic [7:0] in_bucket = '0, hw_bucket = '0, hw_ptr = '0;
    logic [31:0] in_key = '0;
    logic [15:0] in_value = '0;
    logic in_ready, out_valid, out_head_ptr_val, clear_done;
    ht_cmd_t out_cmd;
    logic [7:0] out_bucket, out_head_ptr;
    logic [31:0] out_key, stat_lookups, stat_empty;
    logic [15:0] out_value;

    head_table_lookup #(.OUT_BUF_DEPTH(DEPTH)) dut (
        .clk_i(clk), .rst_i(rst),
        .in_valid_i(in_valid), .in_ready_o(in_ready), .in_cmd_i(in_cmd), .in_bucket_i(in_bucket),
        .in_key_i(in_key), .in_value_i(in_value),
        .out_valid_o(out_valid), .out_ready_i(out_ready), .out_cmd_o(out_cmd), .out_bucket_o(out_bucket),
        .out_key_o(out_key), .out_value_o(out_value), .out_head_ptr_o(out_head_ptr),
        .out_head_ptr_val_o(out_head_ptr_val),
        .hw_en_i(hw_en), .hw_bucket_i(hw_bucket), .hw_ptr_i(hw_ptr), .hw_ptr_val_i(hw_ptr_val),
        .clear_run_i(clear_run), .clear_done_o(clear_done),
        .stat_lookups_o(stat_lookups), .stat_empty_o(stat_empty)
    );

    always #5 clk = ~clk;

    int n_chk = 0, n_fail = 0, n_pop = 0, n_acc = 0;
    int unsigned cyc = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    typedef struct {
        int unsigned acc;
        ht_cmd_t cmd;
        logic [7:0] b;
        logic [31:0] k;
        logic [15:0] v;
        logic [7:0] p;
        logic pv;
    } exp_t;

    exp_t q[$];
    exp_t e;
    logic [8:0] tbl [256];
    bit clearing = 1'b0, just_rst = 1'b1, wr_ok;
    int clr_left = 0;
    int unsigned st_l = 0, st_e = 0;

    // per-cycle reference: everything sampled mid-cycle, effects applied as of the coming edge
    always @(negedge clk) begin
        if (rst) begin
            q.delete();
            clearing = 1'b0;
            just_rst = 1'b1;
            st_l = 0;
            st_e = 0;
        end else begin
            cyc++;
            chk("in_ready", in_ready, !just_rst && !clearing && q.size() < DEPTH);
            chk("out_valid", out_valid, (q.size() != 0) ? (cyc - q[0].acc >= 2) : 1'b0);
            chk("stat_lookups", stat_lookups, STATS ? st_l : 0);
            chk("stat_empty", stat_empty, STATS ? st_e : 0);
            if (out_valid && out_ready && q.size() != 0) begin
                e = q.pop_front();
                chk("res_req", {out_cmd, out_bucket, out_key, out_value}, {e.cmd, e.b, e.k, e.v});
                chk("res_ptr", {out_head_ptr, out_head_ptr_val}, {e.p, e.pv});
                st_l++;
                if (!e.pv) st_e++;
                n_pop++;
            end
            wr_ok = hw_en && !clearing;
            if (in_valid && in_ready) begin
                e.acc = cyc;
                e.cmd = in_cmd;
                e.b = in_bucket;
                e.k = in_key;
                e.v = in_value;
                {e.p, e.pv} = (wr_ok && hw_bucket == in_bucket) ? {hw_ptr, hw_ptr_val} : tbl[in_bucket];
                q.push_back(e);
                n_acc++;
            end
            if (wr_ok) tbl[hw_bucket] = {hw_ptr, hw_ptr_val};
            chk("clear_done", clear_done, clearing && clr_left == 1 && !clear_run);
            if (clear_run) begin
                clearing = 1'b1;
                clr_left = 256;
                st_l = 0;
                st_e = 0;
            end else if (clearing) begin
                clr_left--;
                if (clr_left == 0) begin
                    clearing = 1'b0;
                    for (int i = 0; i < 256; i++) tbl[i] = '0;
                end
            end
            just_rst = 1'b0;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        hw_en = 1'b0;
        clear_run = 1'b0;
    endtask

    task automatic run_clear(input string tag);
        int k = 0;
        clear_run = 1'b1;
        tick();
        k = 1;
        while (!clear_done && k < 300) begin
            tick();
            k++;
        end
        chk(tag, k, 256);
        tick();
    endtask

    function automatic logic [7:0] pick();
        int r = $urandom_range(0, 9);
        return r == 0 ? 8'h00 : r == 1 ? 8'hFF : 8'h20 + 8'($urandom_range(0, 7));
    endfunction

    initial begin
        int n0, a0, k;
        bit saw_ready;
        for (int i = 0; i < 256; i++) tbl[i] = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_outs", {out_valid, in_ready, clear_done, out_head_ptr, out_head_ptr_val, out_key}, '0);
        rst = 1'b0;
        tick();

        run_clear("clr_latency");
        in_valid = 1'b1; in_bucket = 8'h37;
        tick(); tick();
        chk("empty_0x37", {out_valid, out_head_ptr_val}, 2'b10);
        tick();

        hw_en = 1'b1; hw_bucket = 8'h10; hw_ptr = 8'h5A; hw_ptr_val = 1'b1;
        tick();
        in_valid = 1'b1; in_bucket = 8'h10; in_key = 32'hCAFE0010;
        tick();
        chk("lat_n1", out_valid, 1'b0);
        tick();
        chk("lat_n2", {out_valid, out_head_ptr, out_head_ptr_val}, {1'b1, 8'h5A, 1'b1});
        tick();

        in_valid = 1'b1; in_bucket = 8'h22;
        hw_en = 1'b1; hw_bucket = 8'h22; hw_ptr = 8'h11; hw_ptr_val = 1'b1;
        tick();
        hw_en = 1'b1; hw_bucket = 8'h22; hw_ptr = 8'h33; hw_ptr_val = 1'b1;
        tick();
        chk("bypass", {out_valid, out_head_ptr}, {1'b1, 8'h11});
        in_valid = 1'b1; in_bucket = 8'h22;
        tick(); tick();
        chk("after_wr", {out_valid, out_head_ptr}, {1'b1, 8'h33});
        tick();

        n0 = n_pop; a0 = n_acc;
        for (int i = 0; i < 100; i++) begin
            in_valid = 1'b1; in_bucket = pick(); in_key = 32'(i); in_cmd = ht_cmd_t'($urandom_range(0, 2));
            tick();
        end
        in_cmd = HT_SEARCH;
        repeat (3) tick();
        chk("b2b_acc", n_acc - a0, 100);
        chk("b2b_pop", n_pop - n0, 100);

        out_ready = 1'b0; a0 = n_acc;
        for (int i = 0; i < 8; i++) begin
            in_valid = 1'b1; in_bucket = 8'hFF; in_key = 32'hD0000000 + 32'(i);
            tick();
        end
        chk("bp_acc", n_acc - a0, 4);
        chk("bp_ready", in_ready, 1'b0);
        chk("bp_head", {out_valid, out_key}, {1'b1, 32'hD0000000});
        repeat (3) tick();
        chk("bp_hold", {out_valid, out_key}, {1'b1, 32'hD0000000});
        out_ready = 1'b1;
        repeat (6) tick();

        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            in_valid = 1'b1; in_bucket = 8'h40 + 8'(i);
            tick();
        end
        clear_run = 1'b1;
        tick();
        n0 = n_pop; out_ready = 1'b1; saw_ready = 1'b0; k = 1;
        while (!clear_done && k < 300) begin
            if (k == 10) begin
                hw_en = 1'b1; hw_bucket = 8'h00; hw_ptr = 8'h77; hw_ptr_val = 1'b1;
            end
            in_valid = 1'b1; in_bucket = 8'h50;
            saw_ready |= in_ready;
            tick();
            k++;
        end
        chk("clr2_latency", k, 256);
        chk("clr2_blocked", saw_ready, 1'b0);
        chk("clr2_drain", n_pop - n0, 3);
        tick();
        in_valid = 1'b1; in_bucket = 8'h00;
        tick(); tick();
        chk("clr2_dropped", {out_valid, out_head_ptr, out_head_ptr_val}, {1'b1, 8'h00, 1'b0});
        tick();

        out_ready = 1'b0;
        for (int i = 0; i < 2; i++) begin
            in_valid = 1'b1; in_bucket = 8'h20 + 8'(i);
            tick();
        end
        tick();
        rst = 1'b1;
        #1;
        chk("rst_mid_valid", out_valid, 1'b0);
        tick();
        rst = 1'b0;
        out_ready = 1'b1; n0 = n_pop;
        repeat (5) tick();
        chk("rst_no_stale", {out_valid, 32'(n_pop - n0)}, '0);

        run_clear("clr3_latency");
        for (int i = 1; i <= 6; i++) begin
            hw_en = 1'b1; hw_bucket = 8'(i); hw_ptr = 8'(i); hw_ptr_val = 1'b1;
            tick();
        end
        for (int i = 0; i < 10; i++) begin
            in_valid = 1'b1; in_bucket = i < 6 ? 8'(i + 1) : 8'h80 + 8'(i);
            tick();
        end
        repeat (4) tick();
        chk("stat_10", stat_lookups, STATS ? 32'd10 : 32'd0);
        chk("stat_4", stat_empty, STATS ? 32'd4 : 32'd0);

        for (int t = 0; t < 800; t++) begin
            in_valid = $urandom_range(0, 9) < 7;
            in_cmd = ht_cmd_t'($urandom_range(0, 2));
            in_bucket = pick();
            in_key = $urandom;
            in_value = 16'($urandom);
            out_ready = $urandom_range(0, 9) < 7;
            hw_en = $urandom_range(0, 9) < 4;
            hw_bucket = pick();
            hw_ptr = 8'($urandom);
            hw_ptr_val = 1'($urandom);
            clear_run = $urandom_range(0, 399) == 0;
            tick();
        end
        out_ready = 1'b1;
        for (int t = 0; t < 60 && q.size() != 0; t++) tick();
        chk("final_drain", q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
